// File: rtl/cumsum_feeder.sv
// Stimulus source and result checker for the cumulative-sum accumulator.
// Streams a host-loaded sample buffer, predicts the sum and compares the reply.
module cumsum_feeder #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk_data,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [7:0]               n_cfg,
    input  logic                     go,
    output logic                     busy,
    output logic                     cfg_err,
    output logic                     start_out,
    output logic [7:0]               n_out,
    output logic [7:0]               data_out,
    input  logic                     done_in,
    input  logic [15:0]              sum_in,
    output logic [15:0]              exp_sum,
    output logic                     result_valid,
    output logic                     match,
    output logic                     timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT,
        S_REPORT
    } state_t;

    state_t state, state_nx;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] idx, idx_nx, idx_inc;
    logic [7:0]    n_lat, n_lat_nx;
    logic [CW-1:0] wcnt, wcnt_nx;
    logic [15:0]   exp_nx;
    logic [7:0]    data_nx, n_out_nx;
    logic          match_nx, to_nx, cfg_err_nx;
    logic          cfg_ok, last, expired;

    assign cfg_ok  = (n_cfg != 8'd0) && (n_cfg <= 8'(DEPTH));
    assign last    = (8'(idx) == n_lat - 8'd1);
    assign expired = (wcnt == CW'(TIMEOUT));
    assign idx_inc = idx + 1'b1;

    // Buffer has no reset; host reloads it before each self-test.
    always_ff @(posedge clk_data) begin
        if (wr_en && !busy)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            n_lat        <= 8'd0;
            wcnt         <= '0;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
            start_out    <= 1'b0;
            n_out        <= 8'd0;
            data_out     <= 8'd0;
            exp_sum      <= 16'd0;
            result_valid <= 1'b0;
            match        <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            n_lat        <= n_lat_nx;
            wcnt         <= wcnt_nx;
            busy         <= (state_nx != S_IDLE);
            cfg_err      <= cfg_err_nx;
            start_out    <= (state_nx == S_START);
            n_out        <= n_out_nx;
            data_out     <= data_nx;
            exp_sum      <= exp_nx;
            result_valid <= (state_nx == S_REPORT);
            match        <= match_nx;
            timeout      <= to_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (go && cfg_ok) state_nx = S_START;
            S_START:  state_nx = S_STREAM;
            S_STREAM: if (last) state_nx = S_WAIT;
            S_WAIT:   if (done_in || expired) state_nx = S_REPORT;
            S_REPORT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Values computed here are registered, so they appear in the next state.
    always_comb begin
        idx_nx     = idx;
        n_lat_nx   = n_lat;
        wcnt_nx    = wcnt;
        exp_nx     = exp_sum;
        match_nx   = match;
        to_nx      = timeout;
        data_nx    = 8'd0;
        cfg_err_nx = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (go && cfg_ok) begin
                    n_lat_nx = n_cfg;
                    idx_nx   = '0;
                    exp_nx   = 16'd0;
                    match_nx = 1'b0;
                    to_nx    = 1'b0;
                end else if (go) begin
                    cfg_err_nx = 1'b1;
                end
            end
            S_START: data_nx = mem[idx];
            S_STREAM: begin
                exp_nx = exp_sum + {8'd0, data_out};
                if (last) begin
                    wcnt_nx = '0;
                end else begin
                    idx_nx  = idx_inc;
                    data_nx = mem[idx_inc];
                end
            end
            S_WAIT: begin
                if (done_in) begin
                    to_nx    = 1'b0;
                    match_nx = (sum_in == exp_sum);
                end else if (expired) begin
                    to_nx    = 1'b1;
                    match_nx = 1'b0;
                end else begin
                    wcnt_nx = wcnt + 1'b1;
                end
            end
            S_REPORT: ;
            default: ;
        endcase
        n_out_nx = (state_nx != S_IDLE) ? n_lat_nx : 8'd0;
    end

endmodule

// File: tb/tb_cumsum_feeder.sv
// Directed bench for cumsum_feeder with a behavioural accumulator
// answering on the falling edge.
module tb_cumsum_feeder;

    logic        clk_data = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [7:0]  wr_data = 8'd0;
    logic [7:0]  n_cfg = 8'd0;
    logic        go = 1'b0;
    logic        busy, cfg_err, start_out;
    logic [7:0]  n_out, data_out;
    logic        done_in = 1'b0;
    logic [15:0] sum_in = 16'd0;
    logic [15:0] exp_sum;
    logic        result_valid, match, timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model [16];
    bit          acc_on = 1'b1;
    logic [15:0] sum_off = 16'd0;
    int          acc = 0;
    int          acnt = 0;
    int          an = 0;

    cumsum_feeder dut (
        .clk_data(clk_data), .rst(rst), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .n_cfg(n_cfg),
        .go(go), .busy(busy), .cfg_err(cfg_err),
        .start_out(start_out), .n_out(n_out), .data_out(data_out),
        .done_in(done_in), .sum_in(sum_in), .exp_sum(exp_sum),
        .result_valid(result_valid), .match(match), .timeout(timeout)
    );

    always #5 clk_data = ~clk_data;

    // Accumulator stand-in: acts on the falling edge like the real one.
    always @(negedge clk_data) begin
        if (start_out) begin
            acc = 0; acnt = 0; an = int'(n_out); done_in = 1'b0;
        end else if (acnt < an) begin
            acc = acc + int'(data_out);
            acnt++;
            if (acnt == an && acc_on) done_in = 1'b1;
        end
        sum_in = 16'(acc) + sum_off;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk_data);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = 8'(d);
        @(negedge clk_data);
        wr_en = 1'b0;
        model[a] = 8'(d);
    endtask

    // k=1 is the START cycle; elat is the cycle index of REPORT.
    task automatic run(input int n, input int esum, input bit emat,
                       input bit eto, input int elat,
                       input bit wv, input int wd);
        int rv_at, bcnt;
        @(negedge clk_data);
        n_cfg = 8'(n); go = 1'b1;
        if (wv) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'(wd);
            model[0] = 8'(wd);
        end
        @(negedge clk_data);
        go = 1'b0; wr_en = 1'b0;
        rv_at = 0; bcnt = 0;
        for (int k = 1; k <= 60 && rv_at == 0; k++) begin
            if (k > 1) @(negedge clk_data);
            if (busy) bcnt++;
            if (k == 1) begin
                chk("start_out", start_out, 1);
                chk("n_out", n_out, n);
                chk("start_data", data_out, 0);
            end
            if (k >= 2 && k <= n + 1)
                chk($sformatf("data%0d", k - 2), data_out, model[k-2]);
            if (result_valid) begin
                rv_at = k;
                chk("exp_sum", exp_sum, esum);
                chk("match", match, emat);
                chk("timeout", timeout, eto);
            end
        end
        chk("rv_latency", rv_at, elat);
        chk("busy_cycles", bcnt, elat);
        @(negedge clk_data);
        chk("idle_busy", busy, 0);
        chk("idle_n_out", n_out, 0);
    endtask

    task automatic bad_cfg(input int n);
        @(negedge clk_data);
        n_cfg = 8'(n); go = 1'b1;
        @(negedge clk_data);
        go = 1'b0;
        chk($sformatf("cfg_err_%0d", n), cfg_err, 1);
        chk("cfg_busy", busy, 0);
        chk("cfg_start", start_out, 0);
        @(negedge clk_data);
        chk("cfg_err_drop", cfg_err, 0);
        chk("cfg_busy2", busy, 0);
    endtask

    initial begin
        int rv_seen;
        repeat (3) @(negedge clk_data);
        chk("rst_busy", busy, 0);
        chk("rst_start", start_out, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_match", match, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_n_out", n_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_exp_sum", exp_sum, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) wr(i, i + 1);
        run(4, 10, 1, 0, 7, 0, 0);

        for (int i = 0; i < 16; i++) wr(i, 255);
        run(16, 4080, 1, 0, 19, 0, 0);

        bad_cfg(0);
        bad_cfg(17);

        wr(0, 5); wr(1, 6); wr(2, 7);
        acc_on = 1'b0;
        run(3, 18, 0, 1, 21, 0, 0);
        acc_on = 1'b1;

        sum_off = 16'd1;
        run(3, 18, 0, 0, 6, 0, 0);
        sum_off = 16'd0;

        @(negedge clk_data);
        n_cfg = 8'd4; go = 1'b1;
        @(negedge clk_data);
        go = 1'b0;
        @(negedge clk_data);
        @(negedge clk_data);
        chk("second_stream", data_out, model[1]);
        rst = 1'b1;
        @(negedge clk_data);
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_n_out", n_out, 0);
        rv_seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (result_valid) rv_seen++;
            @(negedge clk_data);
        end
        chk("mid_rst_no_rv", rv_seen, 0);

        run(4, 273, 1, 0, 7, 0, 0);

        fork
            run(2, 11, 1, 0, 5, 0, 0);
            begin
                @(negedge clk_data);
                @(negedge clk_data);
                wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hAA;
                @(negedge clk_data);
                wr_en = 1'b0;
            end
        join
        run(1, 5, 1, 0, 4, 0, 0);

        run(1, 9, 1, 0, 4, 1, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
